tap_controller: RTL

Sixteen-state IEEE 1149.1 TAP controller for the JTAG block, clocked by TCK and steered by TMS. It sits directly upstream of the bypass register and the other data/instruction registers. It supplies the Capture/Shift/Update strobes those registers act on (CaptureDR, ShiftDR, and so on), plus the IR/DR path select and the TDO enable used by the output mux.

---
 rtl/tap_controller.sv | 116 +++++++++++
 1 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM on TCK/TMS with decoded
// capture/shift/update strobes, IR/DR path select and TDO enable.
module tap_controller (
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output logic [3:0] state,
    output logic       TestLogicReset,
    output logic       RunTestIdle,
    output logic       CaptureDR,
    output logic       ShiftDR,
    output logic       UpdateDR,
    output logic       CaptureIR,
    output logic       ShiftIR,
    output logic       UpdateIR,
    output logic       Select,
    output logic       Enable
);

    // Codes follow the classic 1149.1 reference encoding; all 16 are legal.
    typedef enum logic [3:0] {
        TLR   = 4'hF,
        RTI   = 4'hC,
        SELDR = 4'h7,
        CAPDR = 4'h6,
        SHDR  = 4'h2,
        EX1DR = 4'h1,
        PAUDR = 4'h3,
        EX2DR = 4'h0,
        UPDDR = 4'h5,
        SELIR = 4'h4,
        CAPIR = 4'hE,
        SHIR  = 4'hA,
        EX1IR = 4'h9,
        PAUIR = 4'hB,
        EX2IR = 4'h8,
        UPDIR = 4'hD
    } tap_state_t;

    tap_state_t state_reg;
    tap_state_t state_next;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_reg <= TLR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TLR:   state_next = TMS ? TLR   : RTI;
            RTI:   state_next = TMS ? SELDR : RTI;
            SELDR: state_next = TMS ? SELIR : CAPDR;
            CAPDR: state_next = TMS ? EX1DR : SHDR;
            SHDR:  state_next = TMS ? EX1DR : SHDR;
            EX1DR: state_next = TMS ? UPDDR : PAUDR;
            PAUDR: state_next = TMS ? EX2DR : PAUDR;
            EX2DR: state_next = TMS ? UPDDR : SHDR;
            UPDDR: state_next = TMS ? SELDR : RTI;
            SELIR: state_next = TMS ? TLR   : CAPIR;
            CAPIR: state_next = TMS ? EX1IR : SHIR;
            SHIR:  state_next = TMS ? EX1IR : SHIR;
            EX1IR: state_next = TMS ? UPDIR : PAUIR;
            PAUIR: state_next = TMS ? EX2IR : PAUIR;
            EX2IR: state_next = TMS ? UPDIR : SHIR;
            UPDIR: state_next = TMS ? SELDR : RTI;
            default: state_next = TLR;
        endcase
    end

    // Outputs decode the state register alone so they never glitch on TMS.
    always_comb begin
        TestLogicReset = 1'b0;
        RunTestIdle    = 1'b0;
        CaptureDR      = 1'b0;
        ShiftDR        = 1'b0;
        UpdateDR       = 1'b0;
        CaptureIR      = 1'b0;
        ShiftIR        = 1'b0;
        UpdateIR       = 1'b0;
        Select         = 1'b0;
        Enable         = 1'b0;
        case (state_reg)
            TLR:   TestLogicReset = 1'b1;
            RTI:   RunTestIdle    = 1'b1;
            CAPDR: CaptureDR      = 1'b1;
            SHDR:  begin
                ShiftDR = 1'b1;
                Enable  = 1'b1;
            end
            UPDDR: UpdateDR       = 1'b1;
            SELIR: Select         = 1'b1;
            CAPIR: begin
                CaptureIR = 1'b1;
                Select    = 1'b1;
            end
            SHIR:  begin
                ShiftIR = 1'b1;
                Select  = 1'b1;
                Enable  = 1'b1;
            end
            EX1IR, PAUIR, EX2IR: Select = 1'b1;
            UPDIR: begin
                UpdateIR = 1'b1;
                Select   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_reg;

endmodule
